// File: rtl/kbest_decision_out_if.sv
// Output-stage bus of the K-best detector: survivor list in, hard decision + LLRs out.
`ifndef ERR_WL
`define ERR_WL 12
`endif

interface kbest_decision_out_if #(
  parameter int N      = 4,
  parameter int LLR_WL = 8,
  parameter int ERR_WL = `ERR_WL
);
  logic                    in_valid;
  logic                    in_ready;
  logic [4*N*2-1:0]        path_in;
  logic [4*ERR_WL-1:0]     ped_in;
  logic                    out_valid;
  logic                    out_ready;
  logic [N*2-1:0]          out_bits;
  logic [N*2*LLR_WL-1:0]   out_llr;
  logic [ERR_WL-1:0]       out_ped;
  logic                    overflow;

  modport master (
    output in_valid, path_in, ped_in, out_ready,
    input  in_ready, out_valid, out_bits, out_llr, out_ped, overflow
  );

  modport slave (
    input  in_valid, path_in, ped_in, out_ready,
    output in_ready, out_valid, out_bits, out_llr, out_ped, overflow
  );
endinterface

// File: rtl/kbest_decision_out.sv
// Picks the min-PED survivor, derives max-log LLRs over the 4-path list and queues
// results in a small fall-through FIFO guarded by an advisory credit signal.
`ifndef ERR_WL
`define ERR_WL 12
`endif

module kbest_decision_out #(
  parameter int N      = 4,
  parameter int DEPTH  = 4,
  parameter int LLR_WL = 8,
  parameter int ERR_WL = `ERR_WL
) (
  input  logic                 clk,
  input  logic                 rst,
  kbest_decision_out_if.slave  bus
);
  localparam int PW   = N * 2;
  localparam int AW   = $clog2(DEPTH);
  localparam int CW   = AW + 1;
  localparam int LMAX = 2 ** (LLR_WL - 1) - 1;
  localparam logic [LLR_WL-1:0] LLR_POS = LLR_WL'(LMAX);
  localparam logic [LLR_WL-1:0] LLR_NEG = LLR_WL'(-LMAX);

  // S1: raw survivor list
  logic              v1_reg;
  logic [PW-1:0]     path1_reg [4];
  logic [ERR_WL-1:0] ped1_reg  [4];

  // S2: per-pair winner plus per-bit class minima, indexed [(pair*2+val)*PW+bit]
  logic              v2_reg;
  logic [PW-1:0]     ppath_next [2];
  logic [ERR_WL-1:0] pped_next  [2];
  logic [4*PW-1:0]   chas_next;
  logic [ERR_WL-1:0] cmin_next  [4*PW];
  logic [PW-1:0]     ppath2_reg [2];
  logic [ERR_WL-1:0] pped2_reg  [2];
  logic [4*PW-1:0]   chas2_reg;
  logic [ERR_WL-1:0] cmin2_reg  [4*PW];

  // S3: final decision
  logic               v3_reg;
  logic               b1_wins;
  logic [PW-1:0]      best_path_next;
  logic [ERR_WL-1:0]  best_ped_next;
  logic [PW*LLR_WL-1:0] llr_next;
  logic [PW-1:0]      bits3_reg;
  logic [ERR_WL-1:0]  ped3_reg;
  logic [PW*LLR_WL-1:0] llr3_reg;

  // FIFO
  logic [PW-1:0]        mem_bits [DEPTH];
  logic [ERR_WL-1:0]    mem_ped  [DEPTH];
  logic [PW*LLR_WL-1:0] mem_llr  [DEPTH];
  logic [AW-1:0]        wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]        count_reg;
  logic                 overflow_reg;
  logic                 push, pop, in_ready, out_valid;

  // Credit counts everything already committed downstream of the input.
  assign in_ready  = (int'(count_reg) + int'(v1_reg) + int'(v2_reg) + int'(v3_reg)) < DEPTH;
  assign out_valid = (count_reg != '0);
  assign push      = v3_reg;
  assign pop       = out_valid & bus.out_ready;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.overflow  = overflow_reg;
  assign bus.out_bits  = out_valid ? mem_bits[rd_ptr_reg] : '0;
  assign bus.out_ped   = out_valid ? mem_ped[rd_ptr_reg]  : '0;
  assign bus.out_llr   = out_valid ? mem_llr[rd_ptr_reg]  : '0;

  for (genvar gi = 0; gi < 2; gi++) begin : g_pair
    logic b_wins;
    assign b_wins         = ped1_reg[2*gi+1] < ped1_reg[2*gi];
    assign pped_next[gi]  = b_wins ? ped1_reg[2*gi+1]  : ped1_reg[2*gi];
    assign ppath_next[gi] = b_wins ? path1_reg[2*gi+1] : path1_reg[2*gi];
    for (genvar gv = 0; gv < 2; gv++) begin : g_val
      for (genvar gb = 0; gb < PW; gb++) begin : g_bit
        logic ha, hb;
        assign ha = (path1_reg[2*gi][gb]   == 1'(gv));
        assign hb = (path1_reg[2*gi+1][gb] == 1'(gv));
        assign chas_next[(gi*2+gv)*PW+gb] = ha | hb;
        assign cmin_next[(gi*2+gv)*PW+gb] =
          (ha && (!hb || ped1_reg[2*gi] <= ped1_reg[2*gi+1])) ? ped1_reg[2*gi] : ped1_reg[2*gi+1];
      end
    end
  end

  // Pair 0 holds the lower path indices, so it wins ties.
  assign b1_wins        = pped2_reg[1] < pped2_reg[0];
  assign best_path_next = b1_wins ? ppath2_reg[1] : ppath2_reg[0];
  assign best_ped_next  = b1_wins ? pped2_reg[1]  : pped2_reg[0];

  for (genvar gb = 0; gb < PW; gb++) begin : g_llr
    logic                h0, h1;
    logic [ERR_WL-1:0]   m0, m1;
    logic signed [ERR_WL:0] diff;
    logic [LLR_WL-1:0]   llr_b;
    assign h0 = chas2_reg[gb] | chas2_reg[2*PW+gb];
    assign h1 = chas2_reg[PW+gb] | chas2_reg[3*PW+gb];
    assign m0 = (chas2_reg[gb] && (!chas2_reg[2*PW+gb] || cmin2_reg[gb] <= cmin2_reg[2*PW+gb]))
                ? cmin2_reg[gb] : cmin2_reg[2*PW+gb];
    assign m1 = (chas2_reg[PW+gb] && (!chas2_reg[3*PW+gb] || cmin2_reg[PW+gb] <= cmin2_reg[3*PW+gb]))
                ? cmin2_reg[PW+gb] : cmin2_reg[3*PW+gb];
    assign diff = $signed({1'b0, m1}) - $signed({1'b0, m0});
    always_comb begin
      llr_b = diff[LLR_WL-1:0];
      if (best_path_next[gb] ? !h0 : !h1)
        llr_b = best_path_next[gb] ? LLR_NEG : LLR_POS;
      else if (int'(diff) > LMAX)
        llr_b = LLR_POS;
      else if (int'(diff) < -LMAX)
        llr_b = LLR_NEG;
    end
    assign llr_next[gb*LLR_WL +: LLR_WL] = llr_b;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_reg <= 1'b0;
      v2_reg <= 1'b0;
      v3_reg <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        path1_reg[i] <= '0;
        ped1_reg[i]  <= '0;
      end
      for (int i = 0; i < 2; i++) begin
        ppath2_reg[i] <= '0;
        pped2_reg[i]  <= '0;
      end
      for (int i = 0; i < 4*PW; i++) cmin2_reg[i] <= '0;
      chas2_reg <= '0;
      bits3_reg <= '0;
      ped3_reg  <= '0;
      llr3_reg  <= '0;
    end else begin
      v1_reg     <= bus.in_valid & in_ready;
      for (int i = 0; i < 4; i++) begin
        path1_reg[i] <= bus.path_in[i*PW +: PW];
        ped1_reg[i]  <= bus.ped_in[i*ERR_WL +: ERR_WL];
      end
      v2_reg     <= v1_reg;
      ppath2_reg <= ppath_next;
      pped2_reg  <= pped_next;
      chas2_reg  <= chas_next;
      cmin2_reg  <= cmin_next;
      v3_reg     <= v2_reg;
      bits3_reg  <= best_path_next;
      ped3_reg   <= best_ped_next;
      llr3_reg   <= llr_next;
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_bits[wr_ptr_reg] <= bits3_reg;
      mem_ped[wr_ptr_reg]  <= ped3_reg;
      mem_llr[wr_ptr_reg]  <= llr3_reg;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      overflow_reg <= 1'b0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
      if (push && !pop)      count_reg <= count_reg + CW'(1);
      else if (pop && !push) count_reg <= count_reg - CW'(1);
      if (bus.in_valid && !in_ready) overflow_reg <= 1'b1;
    end
  end
endmodule

// File: tb/tb_kbest_decision_out.sv
// Directed bench for kbest_decision_out: selection, LLRs, saturation, credit/FIFO and reset.
`ifndef ERR_WL
`define ERR_WL 12
`endif

module tb_kbest_decision_out;
  localparam int N = 4, DEPTH = 4, LLR_WL = 8, ERR_WL = `ERR_WL;
  localparam int PW = N * 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  kbest_decision_out_if #(.N(N), .LLR_WL(LLR_WL), .ERR_WL(ERR_WL)) bus ();

  kbest_decision_out #(.N(N), .DEPTH(DEPTH), .LLR_WL(LLR_WL), .ERR_WL(ERR_WL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic load(input logic [7:0] p0, p1, p2, p3,
                      input logic [ERR_WL-1:0] e0, e1, e2, e3);
    bus.path_in = {p3, p2, p1, p0};
    bus.ped_in  = {e3, e2, e1, e0};
  endtask

  task automatic send(input logic [7:0] p0, p1, p2, p3,
                      input logic [ERR_WL-1:0] e0, e1, e2, e3);
    load(p0, p1, p2, p3, e0, e1, e2, e3);
    bus.in_valid = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic pop_one;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset;
    @(posedge clk); #1;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
    n_cmp++; if (bus.overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow: got %b want 0", bus.overflow); end
    n_cmp++; if (bus.out_bits !== 8'h00 || bus.out_ped !== '0 || bus.out_llr !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got bits=%h ped=%0d llr=%h want zeros", bus.out_bits, bus.out_ped, bus.out_llr); end
    rst = 1'b1;
    cycles(1);
  endtask

  task automatic test_select;
    send(8'h00, 8'hE4, 8'h1B, 8'hFF, 40, 12, 12, 90);
    cycles(2);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL select_early: out_valid got %b want 0 at +2", bus.out_valid); end
    cycles(1);
    n_cmp++; if (bus.out_valid !== 1'b1) begin n_bad++; $display("FAIL select_latency: out_valid got %b want 1 at +3", bus.out_valid); end
    n_cmp++; if (bus.out_bits !== 8'hE4) begin n_bad++; $display("FAIL select_bits: got %h want e4", bus.out_bits); end
    n_cmp++; if (bus.out_ped !== 12'd12) begin n_bad++; $display("FAIL select_ped: got %0d want 12", bus.out_ped); end
    n_cmp++; if (bus.out_llr[7:0] !== 8'd0) begin n_bad++; $display("FAIL select_llr0: got %0d want 0", $signed(bus.out_llr[7:0])); end
    pop_one();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL select_pop: out_valid got %b want 0", bus.out_valid); end
    $display("select: bits=%h ped=%0d", 8'hE4, 12);
  endtask

  task automatic test_llr;
    logic [7:0] got;
    send(8'h00, 8'h01, 8'h00, 8'h00, 10, 30, 50, 50);
    cycles(3);
    n_cmp++; if (bus.out_bits !== 8'h00 || bus.out_ped !== 12'd10) begin
      n_bad++; $display("FAIL llr_best: got bits=%h ped=%0d want 00/10", bus.out_bits, bus.out_ped); end
    n_cmp++; if (bus.out_llr[7:0] !== 8'd20) begin n_bad++; $display("FAIL llr_bit0: got %0d want 20", $signed(bus.out_llr[7:0])); end
    for (int b = 1; b < PW; b++) begin
      got = bus.out_llr[b*LLR_WL +: LLR_WL];
      n_cmp++; if (got !== 8'd127) begin n_bad++; $display("FAIL llr_bit%0d: got %0d want 127", b, $signed(got)); end
    end
    pop_one();
    $display("llr: bit0=+20 others=+127");
  endtask

  task automatic test_saturate;
    logic [7:0] got;
    send(8'hFF, 8'hFE, 8'hFF, 8'hFF, 0, 300, 20, 40);
    cycles(3);
    n_cmp++; if (bus.out_bits !== 8'hFF || bus.out_ped !== 12'd0) begin
      n_bad++; $display("FAIL sat_best: got bits=%h ped=%0d want ff/0", bus.out_bits, bus.out_ped); end
    for (int b = 0; b < PW; b++) begin
      got = bus.out_llr[b*LLR_WL +: LLR_WL];
      n_cmp++; if (got !== 8'h81) begin n_bad++; $display("FAIL sat_bit%0d: got %0d want -127", b, $signed(got)); end
    end
    pop_one();
    $display("saturate: all bits -127");
  endtask

  task automatic test_backpressure;
    logic exp_ready;
    bus.out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      load(8'h10 + 8'(k), 8'h00, 8'h00, 8'h00, 1, 100, 100, 100);
      bus.in_valid = 1'b1;
      exp_ready = (k < DEPTH);
      n_cmp++; if (bus.in_ready !== exp_ready) begin n_bad++; $display("FAIL bp_in_ready%0d: got %b want %b", k, bus.in_ready, exp_ready); end
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    n_cmp++; if (bus.overflow !== 1'b1) begin n_bad++; $display("FAIL bp_overflow: got %b want 1", bus.overflow); end
    cycles(4);
    n_cmp++; if (bus.in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_full_ready: got %b want 0", bus.in_ready); end
    n_cmp++; if (bus.out_bits !== 8'h10) begin n_bad++; $display("FAIL bp_hold: got %h want 10", bus.out_bits); end
    bus.out_ready = 1'b1;
    for (int k = 0; k < DEPTH; k++) begin
      n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_bits !== 8'h10 + 8'(k)) begin
        n_bad++; $display("FAIL bp_order%0d: got v=%b bits=%h want 1/%h", k, bus.out_valid, bus.out_bits, 8'h10 + 8'(k)); end
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b0;
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL bp_drained: out_valid got %b want 0", bus.out_valid); end
    $display("backpressure: 4 accepted, overflow set, drained in order");
  endtask

  task automatic test_push_pop;
    bus.out_ready = 1'b0;
    send(8'hA1, 8'h00, 8'h00, 8'h00, 2, 99, 99, 99);
    send(8'hB2, 8'h00, 8'h00, 8'h00, 2, 99, 99, 99);
    send(8'hC3, 8'h00, 8'h00, 8'h00, 2, 99, 99, 99);
    cycles(4);
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL pp_credit3: got %b want 1", bus.in_ready); end
    send(8'hD4, 8'h00, 8'h00, 8'h00, 2, 99, 99, 99);
    cycles(2);
    pop_one();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_bits !== 8'hB2) begin
      n_bad++; $display("FAIL pp_head: got v=%b bits=%h want 1/b2", bus.out_valid, bus.out_bits); end
    n_cmp++; if (bus.in_ready !== 1'b1) begin n_bad++; $display("FAIL pp_count: in_ready got %b want 1", bus.in_ready); end
    pop_one();
    n_cmp++; if (bus.out_bits !== 8'hC3) begin n_bad++; $display("FAIL pp_second: got %h want c3", bus.out_bits); end
    pop_one();
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_bits !== 8'hD4) begin
      n_bad++; $display("FAIL pp_third: got v=%b bits=%h want 1/d4", bus.out_valid, bus.out_bits); end
    pop_one();
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL pp_empty: out_valid got %b want 0", bus.out_valid); end
    $display("push_pop: order b2 c3 d4 kept");
  endtask

  task automatic test_reset_mid;
    bus.out_ready = 1'b0;
    send(8'h31, 8'h00, 8'h00, 8'h00, 3, 80, 80, 80);
    send(8'h32, 8'h00, 8'h00, 8'h00, 3, 80, 80, 80);
    send(8'h33, 8'h00, 8'h00, 8'h00, 3, 80, 80, 80);
    cycles(4);
    send(8'h34, 8'h00, 8'h00, 8'h00, 3, 80, 80, 80);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.overflow !== 1'b1) begin
      n_bad++; $display("FAIL rm_pre: got v=%b ovf=%b want 1/1", bus.out_valid, bus.overflow); end
    #2 rst = 1'b0;
    #1;
    n_cmp++; if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.overflow !== 1'b0) begin
      n_bad++; $display("FAIL rm_async: got v=%b rdy=%b ovf=%b want 0/1/0", bus.out_valid, bus.in_ready, bus.overflow); end
    n_cmp++; if (bus.out_bits !== 8'h00) begin n_bad++; $display("FAIL rm_bits: got %h want 00", bus.out_bits); end
    @(posedge clk); #1;
    rst = 1'b1;
    cycles(5);
    n_cmp++; if (bus.out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stale: out_valid got %b want 0", bus.out_valid); end
    send(8'h5A, 8'h00, 8'h00, 8'h00, 7, 60, 60, 60);
    cycles(3);
    n_cmp++; if (bus.out_valid !== 1'b1 || bus.out_bits !== 8'h5A || bus.out_ped !== 12'd7) begin
      n_bad++; $display("FAIL rm_after: got v=%b bits=%h ped=%0d want 1/5a/7", bus.out_valid, bus.out_bits, bus.out_ped); end
    pop_one();
    $display("reset_mid: queue flushed, fresh sample 5a out");
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    bus.path_in   = '0;
    bus.ped_in    = '0;
    test_reset();
    test_select();
    test_llr();
    test_saturate();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
